// File: rtl/sram_dp_be.sv
// Simple dual-port synchronous SRAM: one write port with byte enables, one read port.
// Optional output register, read-valid strobe and post-reset zero-fill.
module sram_dp_be #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int DEPTH     = 8192,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int OUT_REG   = 0,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wsbn,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/BYTE_W-1:0]   wbe,
  input  logic                       csbn,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic                       init_busy
);

  localparam int NBE = DATA_W / BYTE_W;
  // One extra bit so a non-power-of-two DEPTH compares cleanly against any address.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_BUSY  = (INIT_ZERO != 0) ? 1'b1 : 1'b0;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NBE-1:0]    be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                init_busy_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                run_s;
  logic                user_we_s;
  logic                rd_en_s;
  logic                rd_in_range_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [NBE-1:0]      mem_be_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   d1_r;
  logic                v1_r;

  // Init sequencer next-state: sweep cnt over every word, then hand over to RUN.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else begin
          state_s = ST_INIT;
          cnt_s   = cnt_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
        cnt_s   = '0;
      end
      default: begin
        state_s = RESET_STATE;
        cnt_s   = '0;
      end
    endcase
  end

  // Init sequencer state, fill counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_STATE;
      cnt_r       <= '0;
      init_busy_r <= RESET_BUSY;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      init_busy_r <= (state_s == ST_INIT);
    end
  end

  // Qualify user accesses; nothing from the ports reaches the array while filling.
  always_comb begin
    run_s         = (state_r == ST_RUN);
    rd_in_range_s = ({1'b0, raddr} < DEPTH_EXT);
    user_we_s     = run_s && !wsbn && ({1'b0, waddr} < DEPTH_EXT);
    rd_en_s       = run_s && !csbn;
  end

  // Array write-port mux: zero-fill has priority over the user port.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = waddr;
    mem_wdata_s = wdata;
    mem_be_s    = wbe;
    if (state_r == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = cnt_r;
      mem_wdata_s = '0;
      mem_be_s    = '1;
    end else if (user_we_s) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array: byte-granular write, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NBE; i++) begin
        if (mem_be_s[i]) begin
          mem_r[mem_addr_s][i*BYTE_W +: BYTE_W] <= mem_wdata_s[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word selection; the array read sees pre-write data, so only new-data mode needs a bypass.
  always_comb begin
    rd_word_s = '0;
    if (!rd_in_range_s) begin
      rd_word_s = '0;
    end else if ((RDW_MODE != 0) && user_we_s && (waddr == raddr)) begin
      rd_word_s = merge_bytes(mem_r[raddr], wdata, wbe);
    end else begin
      rd_word_s = mem_r[raddr];
    end
  end

  // Stage-1 read register: data holds when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_r <= '0;
      v1_r <= 1'b0;
    end else if (rd_en_s) begin
      d1_r <= rd_word_s;
      v1_r <= 1'b1;
    end else begin
      v1_r <= 1'b0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] d2_r;
      logic              v2_r;

      // Stage-2 output register: valid follows stage 1, data only advances on a valid result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2_r <= '0;
          v2_r <= 1'b0;
        end else if (v1_r) begin
          d2_r <= d1_r;
          v2_r <= 1'b1;
        end else begin
          v2_r <= 1'b0;
        end
      end

      assign rdata  = d2_r;
      assign rvalid = v2_r;
    end else begin : g_no_out_reg
      assign rdata  = d1_r;
      assign rvalid = v1_r;
    end
  endgenerate

  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: four configurations share one stimulus stream and are each
// compared every cycle with a word-level array model, plus directed scenario checks.
module tb_sram_dp_be;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wsbn = 1'b1;
  logic [3:0]  waddr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wbe = 4'd0;
  logic        csbn = 1'b1;
  logic [3:0]  raddr = 4'd0;

  logic [31:0] rdata_a [4];
  logic        rvalid_a [4];
  logic        busy_a [4];

  int total = 0;
  int bad = 0;

  // Model configuration: u0 base, u1 new-data RDW, u2 output register, u3 DEPTH=12
  int dep [4] = '{16, 16, 16, 12};
  int rdw [4] = '{0, 1, 0, 0};
  int lat [4] = '{1, 1, 2, 1};

  logic [31:0] mm [4][16];
  int          busy_left [4];
  logic        dly_v [4];
  logic [31:0] dly_d [4];
  logic        exp_v [4];
  logic [31:0] exp_d [4];

  always #5 clk = ~clk;

  sram_dp_be #(.DATA_W(32), .BYTE_W(8), .DEPTH(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wsbn(wsbn), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .csbn(csbn), .raddr(raddr), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .init_busy(busy_a[0]));
  sram_dp_be #(.DATA_W(32), .BYTE_W(8), .DEPTH(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(1), .INIT_ZERO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wsbn(wsbn), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .csbn(csbn), .raddr(raddr), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .init_busy(busy_a[1]));
  sram_dp_be #(.DATA_W(32), .BYTE_W(8), .DEPTH(16), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(0), .INIT_ZERO(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wsbn(wsbn), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .csbn(csbn), .raddr(raddr), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .init_busy(busy_a[2]));
  sram_dp_be #(.DATA_W(32), .BYTE_W(8), .DEPTH(12), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .INIT_ZERO(1)) u3 (
    .clk(clk), .rst_n(rst_n), .wsbn(wsbn), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .csbn(csbn), .raddr(raddr), .rdata(rdata_a[3]), .rvalid(rvalid_a[3]), .init_busy(busy_a[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      busy_left[k] = dep[k];
      dly_v[k] = 1'b0;
      dly_d[k] = 32'd0;
      exp_v[k] = 1'b0;
      exp_d[k] = 32'd0;
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_rvalid", k), {31'd0, rvalid_a[k]}, {31'd0, exp_v[k]});
      chk($sformatf("u%0d_init_busy", k), {31'd0, busy_a[k]}, (busy_left[k] > 0) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d_rdata", k), rdata_a[k], exp_d[k]);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs checked while held.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_all();
    #2;
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply inputs, advance the model, check every instance after the edge.
  task automatic cyc(input logic w_n, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic c_n, input logic [3:0] ra);
    logic        rv;
    logic [31:0] rd;
    logic [31:0] nw;
    logic        ov;
    logic [31:0] od;
    wsbn = w_n; waddr = wa; wdata = wd; wbe = be; csbn = c_n; raddr = ra;
    for (int k = 0; k < 4; k++) begin
      rv = 1'b0;
      rd = 32'd0;
      if (busy_left[k] > 0) begin
        mm[k][dep[k] - busy_left[k]] = 32'd0;
        busy_left[k]--;
      end else begin
        rv = !c_n;
        rd = (int'(ra) < dep[k]) ? mm[k][ra] : 32'd0;
        if (!w_n && int'(wa) < dep[k]) begin
          nw = mm[k][wa];
          for (int b = 0; b < 4; b++) begin
            if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
          end
          if (rdw[k] == 1 && wa == ra) rd = nw;
          mm[k][wa] = nw;
        end
      end
      if (lat[k] == 1) begin
        ov = rv; od = rd;
      end else begin
        ov = dly_v[k]; od = dly_d[k];
        dly_v[k] = rv; dly_d[k] = rd;
      end
      exp_v[k] = ov;
      if (ov) exp_d[k] = od;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  initial begin
    int n;
    int g;
    logic [5:0] vbits;
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 16; a++) mm[k][a] = 'x;

    @(posedge clk);
    #1;
    do_reset();

    // Init fill: busy for exactly DEPTH cycles
    n = 0; g = 0;
    while (busy_a[0] && g < 40) begin
      cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
      n++; g++;
    end
    chk("init_busy_cycles", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'(a));
      chk("init_read_valid", {31'd0, rvalid_a[0]}, 32'd1);
      chk("init_read_zero", rdata_a[0], 32'h0000_0000);
    end

    // Byte enables
    cyc(1'b0, 4'd5, 32'hAABB_CCDD, 4'b1111, 1'b1, 4'd0);
    cyc(1'b0, 4'd5, 32'h1122_3344, 4'b0101, 1'b1, 4'd0);
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'd5);
    chk("byte_enable_merge", rdata_a[0], 32'hAA22_CC44);
    cyc(1'b0, 4'd5, 32'h5555_5555, 4'b0000, 1'b0, 4'd5);
    chk("wbe_zero_no_change", rdata_a[0], 32'hAA22_CC44);

    // Read-during-write on addr 3 (still zero from the fill)
    cyc(1'b0, 4'd3, 32'hDEAD_BEEF, 4'b1111, 1'b0, 4'd3);
    chk("rdw_old_data", rdata_a[0], 32'h0000_0000);
    chk("rdw_new_data", rdata_a[1], 32'hDEAD_BEEF);
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'd3);
    chk("rdw_after_mode0", rdata_a[0], 32'hDEAD_BEEF);
    chk("rdw_after_mode1", rdata_a[1], 32'hDEAD_BEEF);

    // Output-register pipeline: three back-to-back reads
    cyc(1'b0, 4'd0, 32'h0000_0100, 4'b1111, 1'b1, 4'd0);
    cyc(1'b0, 4'd1, 32'h0000_0101, 4'b1111, 1'b1, 4'd0);
    cyc(1'b0, 4'd2, 32'h0000_0102, 4'b1111, 1'b1, 4'd0);
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
    vbits = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'(i));
      else       cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
      vbits[i] = rvalid_a[2];
      if (i >= 1 && i <= 3) chk("pipe_data_order", rdata_a[2], 32'h0000_0100 + 32'(i - 1));
    end
    chk("pipe_rvalid_pattern", {26'd0, vbits}, {26'd0, 6'b001110});
    chk("pipe_rdata_hold", rdata_a[2], 32'h0000_0102);

    // Out of range on the DEPTH=12 instance
    cyc(1'b0, 4'd13, 32'hFFFF_FFFF, 4'b1111, 1'b1, 4'd0);
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'd13);
    chk("oor_read_zero", rdata_a[3], 32'h0000_0000);
    chk("oor_read_valid", {31'd0, rvalid_a[3]}, 32'd1);
    for (int a = 0; a < 12; a++) cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'(a));

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of the fill, with writes attempted during busy
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'(i), 32'hFFFF_FFFF, 4'b1111, 1'b0, 4'(i));
    do_reset();
    chk("midreset_busy", {31'd0, busy_a[0]}, 32'd1);
    n = 0; g = 0;
    while (busy_a[0] && g < 40) begin
      cyc(1'b0, 4'($urandom_range(0, 15)), 32'hFFFF_FFFF, 4'b1111, 1'b0, 4'd0);
      n++; g++;
    end
    chk("midreset_busy_cycles", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'(a));
      chk("midreset_read_zero", rdata_a[0], 32'h0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
